key_press_classifier: RTL and testbench

//  N-channel push-button front end: synchronises, debounces and classifies active-low keys into
//  one-cycle short-press, long-press and auto-repeat pulses plus a clean debounced level.

---
 rtl/key_press_classifier_pkg.sv | 14 +
 rtl/key_channel.sv | 133 +++++++++++++
 rtl/key_press_classifier.sv | 35 +++
 tb/tb_key_press_classifier.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/key_press_classifier_pkg.sv
// Shared definitions for the key press classifier: per-channel FSM state encoding.
package key_press_classifier_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_DB_PRESS = 3'd1;
  localparam state_t ST_PRESSED  = 3'd2;
  localparam state_t ST_LONG     = 3'd3;
  localparam state_t ST_DB_REL   = 3'd4;

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, debounce/classify FSM, separate debounce and hold counters.
module key_channel
  import key_press_classifier_pkg::*;
#(
  parameter int DEB_CYC    = 200_000,
  parameter int LONG_CYC   = 50_000_000,
  parameter int REPEAT_EN  = 0,
  parameter int REPEAT_CYC = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int CNT_W = $clog2(LONG_CYC + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic   sync1, sync2;
  logic   pressed;
  state_t state, ret_state;
  logic   [CNT_W-1:0] db_cnt, hold_cnt;
  logic   short_cand;

  // NOTE: synchroniser resets to the released level so a key held through
  // reset is seen as a fresh press and must debounce again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ret_state    <= ST_PRESSED;
      db_cnt       <= '0;
      hold_cnt     <= '0;
      short_cand   <= 1'b0;
      level        <= 1'b0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          db_cnt   <= '0;
          hold_cnt <= '0;
          if (pressed) state <= ST_DB_PRESS;
        end
        ST_DB_PRESS: begin
          if (!pressed) begin
            state  <= ST_IDLE;
            db_cnt <= '0;
          end else if (db_cnt == DEB_LAST) begin
            state    <= ST_PRESSED;
            level    <= 1'b1;
            db_cnt   <= '0;
            hold_cnt <= '0;
          end else begin
            db_cnt <= sat_inc(db_cnt);
          end
        end
        ST_PRESSED: begin
          if (!pressed) begin
            state      <= ST_DB_REL;
            ret_state  <= ST_PRESSED;
            short_cand <= 1'b1;
            db_cnt     <= '0;
          end else if (hold_cnt == LONG_LAST) begin
            state      <= ST_LONG;
            long_pulse <= 1'b1;
            hold_cnt   <= '0;
          end else begin
            hold_cnt <= sat_inc(hold_cnt);
          end
        end
        ST_LONG: begin
          if (!pressed) begin
            state      <= ST_DB_REL;
            ret_state  <= ST_LONG;
            short_cand <= 1'b0;
            db_cnt     <= '0;
          end else if (REPEAT_EN != 0) begin
            if (hold_cnt == REP_LAST) begin
              repeat_pulse <= 1'b1;
              hold_cnt     <= '0;
            end else begin
              hold_cnt <= sat_inc(hold_cnt);
            end
          end
        end
        ST_DB_REL: begin
          // Bounce back to pressed resumes the frozen hold count.
          if (pressed) begin
            state  <= ret_state;
            db_cnt <= '0;
          end else if (db_cnt == DEB_LAST) begin
            state       <= ST_IDLE;
            level       <= 1'b0;
            short_pulse <= short_cand;
            db_cnt      <= '0;
            hold_cnt    <= '0;
          end else begin
            db_cnt <= sat_inc(db_cnt);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_press_classifier.sv
// N-channel push-button front end: independent debounce/classify channel per key.
module key_press_classifier #(
  parameter int NUM_KEYS   = 1,
  parameter int DEB_CYC    = 200_000,
  parameter int LONG_CYC   = 50_000_000,
  parameter int REPEAT_EN  = 0,
  parameter int REPEAT_CYC = 10_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_short,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_channel #(
      .DEB_CYC   (DEB_CYC),
      .LONG_CYC  (LONG_CYC),
      .REPEAT_EN (REPEAT_EN),
      .REPEAT_CYC(REPEAT_CYC)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key_n       (key_n[i]),
      .level       (key_level[i]),
      .short_pulse (key_short[i]),
      .long_pulse  (key_long[i]),
      .repeat_pulse(key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_press_classifier.sv
// Directed bench: short, long/repeat, glitch, release bounce, simultaneous events, mid-hold reset.
module tb_key_press_classifier;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] key_n = 2'b11;
  logic [1:0] key_level, key_short, key_long, key_repeat;

  key_press_classifier #(
    .NUM_KEYS  (2),
    .DEB_CYC   (8),
    .LONG_CYC  (40),
    .REPEAT_EN (1),
    .REPEAT_CYC(10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .key_level (key_level),
    .key_short (key_short),
    .key_long  (key_long),
    .key_repeat(key_repeat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled on the falling edge.
  int n_short[2] = '{0, 0};
  int n_long[2]  = '{0, 0};
  int n_rep[2]   = '{0, 0};
  int n_rise[2]  = '{0, 0};
  int n_fall[2]  = '{0, 0};
  int last_short[2] = '{-1, -1};
  int last_long[2]  = '{-1, -1};
  int last_rep[2]   = '{-1, -1};
  int rise_cyc[2]   = '{-1, -1};
  int fall_cyc[2]   = '{-1, -1};
  logic [1:0] prev_level = 2'b00;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (key_short[i])  begin n_short[i]++; last_short[i] = cyc; end
      if (key_long[i])   begin n_long[i]++;  last_long[i]  = cyc; end
      if (key_repeat[i]) begin n_rep[i]++;   last_rep[i]   = cyc; end
      if (key_level[i] && !prev_level[i]) begin n_rise[i]++; rise_cyc[i] = cyc; end
      if (!key_level[i] && prev_level[i]) begin n_fall[i]++; fall_cyc[i] = cyc; end
    end
    prev_level = key_level;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int c0, d0;
  int b_short[2], b_long[2], b_rep[2], b_rise[2], b_fall[2];

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      b_short[i] = n_short[i];
      b_long[i]  = n_long[i];
      b_rep[i]   = n_rep[i];
      b_rise[i]  = n_rise[i];
      b_fall[i]  = n_fall[i];
    end
  endtask

  initial begin
    // Reset state
    wait_cyc(3);
    check("rst_level",  int'(key_level),  0);
    check("rst_short",  int'(key_short),  0);
    check("rst_long",   int'(key_long),   0);
    check("rst_repeat", int'(key_repeat), 0);
    rst = 1'b0;
    wait_cyc(3);

    // Clean short press on ch0: level rises 11 cycles after drive, short 11 after release
    snap();
    c0 = cyc;
    key_n[0] = 1'b0;
    wait_cyc(20);
    key_n[0] = 1'b1;
    wait_cyc(15);
    check("t1_rise_cyc",   rise_cyc[0], c0 + 11);
    check("t1_short_n",    n_short[0] - b_short[0], 1);
    check("t1_short_cyc",  last_short[0], c0 + 31);
    check("t1_long_n",     n_long[0] - b_long[0], 0);
    check("t1_level_end",  int'(key_level[0]), 0);

    // Long hold on ch0 with repeat: long at +51, repeats at +61 and +71
    snap();
    c0 = cyc;
    key_n[0] = 1'b0;
    wait_cyc(75);
    key_n[0] = 1'b1;
    wait_cyc(15);
    check("t2_long_n",     n_long[0] - b_long[0], 1);
    check("t2_long_cyc",   last_long[0], c0 + 51);
    check("t2_rep_n",      n_rep[0] - b_rep[0], 2);
    check("t2_rep_cyc",    last_rep[0], c0 + 71);
    check("t2_short_n",    n_short[0] - b_short[0], 0);
    check("t2_fall_cyc",   fall_cyc[0], c0 + 86);

    // 3-cycle glitch on ch1: nothing observable
    snap();
    key_n[1] = 1'b0;
    wait_cyc(3);
    key_n[1] = 1'b1;
    wait_cyc(20);
    check("t3_rise_n",  n_rise[1] - b_rise[1], 0);
    check("t3_pulses",  (n_short[1] - b_short[1]) + (n_long[1] - b_long[1]) +
                        (n_rep[1] - b_rep[1]), 0);

    // Release with bounce on ch0: one short, level falls once
    snap();
    c0 = cyc;
    key_n[0] = 1'b0;
    wait_cyc(20);
    key_n[0] = 1'b1;
    wait_cyc(2);
    key_n[0] = 1'b0;
    wait_cyc(2);
    key_n[0] = 1'b1;
    wait_cyc(20);
    check("t4_short_n",   n_short[0] - b_short[0], 1);
    check("t4_short_cyc", last_short[0], c0 + 35);
    check("t4_fall_n",    n_fall[0] - b_fall[0], 1);

    // ch0 short and ch1 long land on the same cycle
    snap();
    c0 = cyc;
    key_n[1] = 1'b0;
    wait_cyc(10);
    key_n[0] = 1'b0;
    wait_cyc(30);
    key_n[0] = 1'b1;
    wait_cyc(15);
    key_n[1] = 1'b1;
    wait_cyc(25);
    check("t5_short0_n",   n_short[0] - b_short[0], 1);
    check("t5_short0_cyc", last_short[0], c0 + 51);
    check("t5_long1_n",    n_long[1] - b_long[1], 1);
    check("t5_long1_cyc",  last_long[1], c0 + 51);
    check("t5_cross",      (n_long[0] - b_long[0]) + (n_short[1] - b_short[1]) +
                           (n_rep[1] - b_rep[1]), 0);

    // Reset during long hold on ch0; key stays held and must re-debounce
    c0 = cyc;
    key_n[0] = 1'b0;
    wait_cyc(55);
    rst = 1'b1;
    #1;
    check("t6_rst_level", int'(key_level),  0);
    check("t6_rst_pulse", int'(key_short | key_long | key_repeat), 0);
    wait_cyc(2);
    snap();
    rst = 1'b0;
    d0 = cyc;
    wait_cyc(30);
    check("t6_rise_n",    n_rise[0] - b_rise[0], 1);
    check("t6_rise_cyc",  rise_cyc[0], d0 + 11);
    check("t6_no_stale",  (n_short[0] - b_short[0]) + (n_long[0] - b_long[0]) +
                          (n_rep[0] - b_rep[0]), 0);
    key_n[0] = 1'b1;
    wait_cyc(15);
    check("t6_fresh_short", n_short[0] - b_short[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
